// File: rtl/txt_writer_pkg.sv
// Shared constants, control codes and FSM state type for the text-mode console writer.
package txt_writer_pkg;

  localparam int COLS   = 40;
  localparam int ROWS   = 30;
  localparam int ADDR_W = 12;

  localparam logic [7:0] BLANK = 8'h20;
  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  localparam logic [5:0]        COL_LAST   = 6'(COLS - 1);
  localparam logic [4:0]        ROW_LAST   = 5'(ROWS - 1);
  localparam logic [ADDR_W-1:0] LINE_LEN   = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] SCREEN_LEN = ADDR_W'(COLS * ROWS);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WRITE    = 2'd1,
    CLR_LINE = 2'd2,
    CLR_ALL  = 2'd3
  } state_t;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

endpackage

// File: rtl/txt_clear_sweep.sv
// Blank-fill address generator shared by the line clear and the full-screen clear.
// start presents base in the same cycle, then one address per cycle up to base+len-1.
module txt_clear_sweep
  import txt_writer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] len,
  output logic [ADDR_W-1:0] addr,
  output logic              en,
  output logic              done
);

  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic              active_q, active_d;

  always_comb begin
    last_d   = start ? (base + len - ADDR_W'(1)) : last_q;
    addr     = start ? base : cnt_q;
    en       = start | active_q;
    done     = en && (addr == last_d);
    cnt_d    = cnt_q;
    active_d = active_q;
    // the counter parks on the last address instead of stepping past the screen
    if (en) begin
      active_d = !done;
      if (!done) begin
        cnt_d = addr + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      last_q   <= '0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/txt_writer.sv
// Console writer: byte stream in, cursor-tracked writes into the 40x30 display RAM out.
// state    | meaning
// IDLE     | ready for a byte
// WRITE    | char write visible on wr_*, cursor moves at the end of this cycle
// CLR_LINE | blanking row 0 after a wrap from the last row
// CLR_ALL  | blanking the whole screen after FF
module txt_writer
  import txt_writer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_char,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [5:0]        cur_col,
  output logic [4:0]        cur_row,
  output logic              busy
);

  state_t            state_q, state_d;
  logic [5:0]        col_q, col_d;
  logic [4:0]        row_q, row_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [7:0]        char_q, char_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;
  logic              sweep_done_q, sweep_done_d;

  logic              accept, ff_start, row_wrap;
  logic              sweep_start, sweep_en, sweep_done;
  logic [ADDR_W-1:0] sweep_len, sweep_addr;

  assign accept      = in_valid && in_ready_q;
  assign ff_start    = (state_q == IDLE) && accept && (in_char == CH_FF);
  assign row_wrap    = (state_q == WRITE) && (row_q == ROW_LAST) &&
                       ((char_q == CH_LF) || (is_printable(char_q) && (col_q == COL_LAST)));
  assign sweep_start = ff_start || row_wrap;
  assign sweep_len   = ff_start ? SCREEN_LEN : LINE_LEN;

  txt_clear_sweep u_sweep (
    .clk   (clk),
    .reset (reset),
    .start (sweep_start),
    .base  ('0),
    .len   (sweep_len),
    .addr  (sweep_addr),
    .en    (sweep_en),
    .done  (sweep_done)
  );

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    row_base_d   = row_base_q;
    char_d       = char_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    sweep_done_d = sweep_done;

    case (state_q)
      IDLE: begin
        if (accept) begin
          char_d = in_char;
          if (is_printable(in_char)) begin
            wr_en_d   = 1'b1;
            wr_addr_d = row_base_q + ADDR_W'(col_q);
            wr_data_d = in_char;
            state_d   = WRITE;
          end else if ((in_char == CH_LF) || (in_char == CH_CR) || (in_char == CH_BS)) begin
            state_d = WRITE;
          end else if (in_char == CH_FF) begin
            col_d      = '0;
            row_d      = '0;
            row_base_d = '0;
            state_d    = CLR_ALL;
          end
        end
      end
      WRITE: begin
        state_d = IDLE;
        if (row_wrap) begin
          col_d      = '0;
          row_d      = '0;
          row_base_d = '0;
          state_d    = CLR_LINE;
        end else if ((char_q == CH_LF) || (is_printable(char_q) && (col_q == COL_LAST))) begin
          col_d      = '0;
          row_d      = row_q + 5'd1;
          row_base_d = row_base_q + LINE_LEN;
        end else if (is_printable(char_q)) begin
          col_d = col_q + 6'd1;
        end else if (char_q == CH_CR) begin
          col_d = '0;
        end else if ((char_q == CH_BS) && (col_q != '0)) begin
          col_d = col_q - 6'd1;
        end
      end
      CLR_LINE, CLR_ALL: begin
        // leave one cycle after the final blank so busy covers every sweep write
        if (sweep_done_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (sweep_en) begin
      wr_en_d   = 1'b1;
      wr_addr_d = sweep_addr;
      wr_data_d = BLANK;
    end

    in_ready_d = (state_d == IDLE);
    busy_d     = (state_d == CLR_LINE) || (state_d == CLR_ALL);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      row_base_q   <= '0;
      char_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      sweep_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      row_base_q   <= row_base_d;
      char_q       <= char_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      sweep_done_q <= sweep_done_d;
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign cur_col  = col_q;
  assign cur_row  = row_q;

endmodule

// File: doc/txt_writer.md
Name: txt_writer

Overview:
Console writer for the 40x30 text-mode display memory, and the write-side counterpart of the text sequencer that reads ASCII codes from this memory and renders them. Accepts a byte stream (CPU or UART) over a valid/ready handshake, interprets control codes and keeps a cursor. Writes character codes into the display RAM write port at address row*COLS+col. Handles line wrap, clear-line on wrap from the last row, and full-screen clear.

Parameters:
COLS, 40, characters per row (640/16)
ROWS, 30, rows per screen (480/16)
ADDR_W, 12, display memory address width
BLANK, 8'h20, fill code used by clear operations

Ports:
clk  input  1  pixel/system clock
reset  input  1  asynchronous, active-low reset
in_valid  input  1  in_char is valid
in_ready  output  1  block can accept a byte this cycle
in_char  input  8  byte to print or interpret
wr_en  output  1  display memory write strobe, one write per cycle
wr_addr  output  ADDR_W  display memory write address
wr_data  output  8  display memory write data
cur_col  output  6  current cursor column, 0..COLS-1
cur_row  output  5  current cursor row, 0..ROWS-1
busy  output  1  a clear-line or clear-screen sweep is in progress

Behaviour:
- Reset (async, active-low) values: state IDLE, cur_col=0, cur_row=0, row_base=0, wr_en=0, wr_addr=0, wr_data=0, in_ready=0, busy=0. in_ready rises in the first cycle after reset deassertion.
- All outputs are registered. in_ready=1 only in IDLE.
- A byte is accepted on the rising edge where in_valid and in_ready are both 1. The byte is ignored while in_ready=0, and the source must hold it.
- row_base register holds cur_row*COLS and is updated by +COLS or reset to 0. No multiplier.
- States: IDLE, WRITE, CLR_LINE, CLR_ALL.
- Printable byte (0x20..0x7E): IDLE->WRITE. In the next cycle wr_en=1, wr_addr=row_base+cur_col, wr_data=byte, so latency is 1 cycle from acceptance. Cursor then advances: col+1. If col was COLS-1, col wraps to 0 and row goes to row+1. Returns to IDLE unless a row wrap occurs.
- 0x0A (LF): col=0, row+1. 0x0D (CR): col=0. 0x08 (BS): col-1, saturating at 0, with no write. None of these three writes memory. Each takes 1 cycle (IDLE->WRITE->IDLE with wr_en=0).
- Row wrap: when row would become ROWS (from a printable byte at col COLS-1 or from LF on row ROWS-1), the block sets row=0, row_base=0, col=0 and enters CLR_LINE.
- CLR_LINE: writes BLANK to addresses 0..COLS-1, one per cycle (40 cycles, wr_en=1 continuously), then goes to IDLE. busy=1 and in_ready=0 throughout.
- 0x0C (FF): enters CLR_ALL. Writes BLANK to addresses 0..COLS*ROWS-1 (0..1199, 1200 cycles). Cursor goes to 0,0 at entry. busy=1, in_ready=0 throughout.
- Any other byte (0x00..0x1F not listed above, or 0x7F..0xFF) is accepted and dropped, with no write and no cursor change.
- A sweep address counter, ADDR_W bits, stops exactly at the last address and never writes beyond COLS*ROWS-1.
- Reset mid-sweep aborts immediately: wr_en=0 and cursor 0,0. Memory contents are left partially cleared, which is acceptable.
- wr_addr is always < COLS*ROWS whenever wr_en=1.

Decomposition:
- Shared package holds: COLS, ROWS, ADDR_W, BLANK, the control-code constants (LF, CR, BS, FF) and the state enum.
- One natural sub-module, txt_clear_sweep: a counter with start, base and length inputs, producing addr/en/done outputs. It serves both CLR_LINE and CLR_ALL.

Test Plan:
- Reset, then send 'A' (0x41) -> exactly one cycle later wr_en=1, wr_addr=0, wr_data=0x41, then cur_col=1, cur_row=0.
- Send 40 printable bytes from 0,0 -> addresses 0..39 are written; cursor ends at col 0, row 1. The 41st byte is written at address 40.
- Cursor at row 29 col 5, send LF -> 40 consecutive cycles of wr_en=1, addr 0..39, data 0x20, in_ready=0, busy=1. Cursor ends at 0,0 and in_ready returns to 1.
- Send FF with the cursor at 10,7 -> 1200 writes, addr 0..1199 of 0x20, with no address above 1199. Cursor is 0,0 at the end and busy drops the cycle after the last write.
- Backspace at col 0 -> no write, cursor unchanged. CR at col 17 -> col 0 with the row unchanged. Byte 0x07 -> no write, no cursor change.
- Hold in_valid=1 with 'B' during a CLR_ALL, then assert reset at sweep address 500 -> no further writes, cursor 0,0. After release, 'B' is accepted and written at addr 0.
